// File: rtl/uart_rx_fifo.sv
// Receive-side frame buffer: captures UART receiver frames with their error flags
// into a first-word-fall-through FIFO, with sticky overflow and error-frame statistics.
module uart_rx_fifo #(
   parameter int DATA_WIDTH      = 8,
   parameter int DEPTH_LOG2      = 4,
   parameter int DROP_ERR_FRAMES = 0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  data_valid,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  Parity_Error,
   input  logic                  Stop_Error,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_par_err,
   output logic                  rd_stp_err,
   output logic                  empty,
   output logic                  full,
   output logic [DEPTH_LOG2:0]   fill_level,
   output logic                  overflow,
   input  logic                  clr_ovf,
   output logic [7:0]            err_frame_cnt
);

   localparam int                    DEPTH     = 1 << DEPTH_LOG2;
   localparam int                    ENTRY_W   = DATA_WIDTH + 2;
   localparam logic [DEPTH_LOG2:0]   CNT_FULL  = (DEPTH_LOG2+1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2+1)'(1);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

   logic [ENTRY_W-1:0]    mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   logic                  dv_q;
   logic                  ovf_q, ovf_d;
   logic [7:0]            err_cnt_q, err_cnt_d;

   logic                  wr_req, err_frame, push, pop;
   logic [ENTRY_W-1:0]    head;

   // A frame is requested only on the rising edge of the receiver strobe.
   assign wr_req    = data_valid & ~dv_q;
   assign err_frame = wr_req & (Parity_Error | Stop_Error);
   assign pop       = rd_en & ~empty;
   assign push      = wr_req & ((DROP_ERR_FRAMES == 0) | ~err_frame) & (~full | pop);

   assign empty      = (count_q == '0);
   assign full       = (count_q == CNT_FULL);
   assign fill_level = count_q;

   always_comb begin
      // NOTE: every next-state signal gets a default first so no latch is inferred.
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      ovf_d     = ovf_q;
      err_cnt_d = err_cnt_q;

      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push && !pop)      count_d = count_q + CNT_ONE;
      else if (pop && !push) count_d = count_q - CNT_ONE;

      // A lost frame in the same cycle as a clear keeps the flag set.
      if (clr_ovf) ovf_d = 1'b0;
      if (wr_req && ((DROP_ERR_FRAMES == 0) || !err_frame) && full && !pop) ovf_d = 1'b1;

      if (err_frame && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: sequential state is updated with non-blocking assignments only.
      if (!reset_n) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         dv_q      <= 1'b0;
         ovf_q     <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         dv_q      <= data_valid;
         ovf_q     <= ovf_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   // NOTE: the storage array has no reset; stale words are never visible because
   // the outputs are masked while the registered count is zero.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {Parity_Error, Stop_Error, P_DATA};
   end

   assign head          = mem_q[rd_ptr_q];
   assign rd_data       = empty ? '0 : head[DATA_WIDTH-1:0];
   assign rd_stp_err    = ~empty & head[DATA_WIDTH];
   assign rd_par_err    = ~empty & head[DATA_WIDTH+1];
   assign overflow      = ovf_q;
   assign err_frame_cnt = err_cnt_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: one keep-all and one drop-errors instance driven in parallel,
// compared against a queue-based model of the frame buffer.
module tb_uart_rx_fifo;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       data_valid;
   logic [7:0] P_DATA;
   logic       Parity_Error, Stop_Error, rd_en, clr_ovf;

   logic [7:0] rdd [2];
   logic       rpe [2];
   logic       rse [2];
   logic       emp [2];
   logic       ful [2];
   logic [4:0] fl  [2];
   logic       ovf [2];
   logic [7:0] efc [2];

   int total = 0;
   int bad   = 0;

   // Model: entries are {parity, stop, data}; index 0 keeps error frames, index 1 drops them.
   logic [9:0] mq [2][$];
   int         mcnt [2];
   bit         movf [2];
   bit         mprev;

   always #5 clk = ~clk;

   uart_rx_fifo #(.DATA_WIDTH(8), .DEPTH_LOG2(4), .DROP_ERR_FRAMES(0)) dut_keep (
      .clk(clk), .reset_n(reset_n), .data_valid(data_valid), .P_DATA(P_DATA),
      .Parity_Error(Parity_Error), .Stop_Error(Stop_Error), .rd_en(rd_en),
      .rd_data(rdd[0]), .rd_par_err(rpe[0]), .rd_stp_err(rse[0]), .empty(emp[0]),
      .full(ful[0]), .fill_level(fl[0]), .overflow(ovf[0]), .clr_ovf(clr_ovf),
      .err_frame_cnt(efc[0]));

   uart_rx_fifo #(.DATA_WIDTH(8), .DEPTH_LOG2(4), .DROP_ERR_FRAMES(1)) dut_drop (
      .clk(clk), .reset_n(reset_n), .data_valid(data_valid), .P_DATA(P_DATA),
      .Parity_Error(Parity_Error), .Stop_Error(Stop_Error), .rd_en(rd_en),
      .rd_data(rdd[1]), .rd_par_err(rpe[1]), .rd_stp_err(rse[1]), .empty(emp[1]),
      .full(ful[1]), .fill_level(fl[1]), .overflow(ovf[1]), .clr_ovf(clr_ovf),
      .err_frame_cnt(efc[1]));

   function automatic logic [9:0] head(int m);
      return (mq[m].size() > 0) ? mq[m][0] : 10'd0;
   endfunction

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         mq[m].delete();
         mcnt[m] = 0;
         movf[m] = 1'b0;
      end
      mprev = 1'b0;
   endtask

   task automatic model_edge(bit dv, logic [7:0] d, bit pe, bit se, bit rd, bit clr);
      bit req, errf, pop, was_full, lost;
      req   = dv && !mprev;
      mprev = dv;
      errf  = req && (pe || se);
      for (int m = 0; m < 2; m++) begin
         was_full = (mq[m].size() == 16);
         pop      = rd && (mq[m].size() > 0);
         lost     = 1'b0;
         if (errf && mcnt[m] < 255) mcnt[m]++;
         if (pop) void'(mq[m].pop_front());
         if (req && !(m == 1 && errf)) begin
            if (!was_full || pop) mq[m].push_back({pe, se, d});
            else lost = 1'b1;
         end
         movf[m] = lost ? 1'b1 : (clr ? 1'b0 : movf[m]);
      end
   endtask

   // Drives one cycle of inputs on the falling edge; outputs are sampled 1 ns after the rising edge.
   task automatic step(bit dv, logic [7:0] d, bit pe, bit se, bit rd, bit clr);
      @(negedge clk);
      data_valid = dv; P_DATA = d; Parity_Error = pe; Stop_Error = se;
      rd_en = rd; clr_ovf = clr;
      @(posedge clk);
      model_edge(dv, d, pe, se, rd, clr);
      #1;
   endtask

   task automatic frame(logic [7:0] d, bit pe, bit se, bit rd);
      step(1'b1, d, pe, se, rd, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      data_valid = 0; P_DATA = 0; Parity_Error = 0; Stop_Error = 0; rd_en = 0; clr_ovf = 0;
      model_reset();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      for (int m = 0; m < 2; m++) begin
         total++;
         if (emp[m] !== 1'b1 || ful[m] !== 1'b0 || fl[m] !== 5'd0 || rdd[m] !== 8'd0 ||
             rpe[m] !== 1'b0 || rse[m] !== 1'b0 || ovf[m] !== 1'b0 || efc[m] !== 8'd0) begin
            bad++;
            $display("FAIL reset[%0d]: got empty=%b full=%b fill=%0d data=%h pe=%b se=%b ovf=%b efc=%0d, want 1 0 0 00 0 0 0 0",
                     m, emp[m], ful[m], fl[m], rdd[m], rpe[m], rse[m], ovf[m], efc[m]);
         end
      end
   endtask

   task automatic test_single();
      step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
      total++;
      if (emp[0] !== 1'b0 || fl[0] !== 5'd1 || rdd[0] !== 8'hA5) begin
         bad++;
         $display("FAIL single_write: got empty=%b fill=%0d data=%h, want 0 1 a5", emp[0], fl[0], rdd[0]);
      end
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      total++;
      if (emp[0] !== 1'b1 || rdd[0] !== 8'h00 || fl[0] !== 5'd0) begin
         bad++;
         $display("FAIL single_pop: got empty=%b fill=%0d data=%h, want 1 0 00", emp[0], fl[0], rdd[0]);
      end
   endtask

   task automatic test_fill_overflow();
      for (int i = 0; i < 16; i++) frame(8'(i), 1'b0, 1'b0, 1'b0);
      total++;
      if (ful[0] !== 1'b1 || ovf[0] !== 1'b0 || fl[0] !== 5'd16) begin
         bad++;
         $display("FAIL fill16: got full=%b ovf=%b fill=%0d, want 1 0 16", ful[0], ovf[0], fl[0]);
      end
      frame(8'hFF, 1'b0, 1'b0, 1'b0);
      total++;
      if (ful[0] !== 1'b1 || ovf[0] !== 1'b1 || fl[0] !== 5'd16) begin
         bad++;
         $display("FAIL overflow: got full=%b ovf=%b fill=%0d, want 1 1 16", ful[0], ovf[0], fl[0]);
      end
      for (int i = 0; i < 16; i++) begin
         total++;
         if (rdd[0] !== 8'(i)) begin
            bad++;
            $display("FAIL drain_order[%0d]: got %h, want %h", i, rdd[0], 8'(i));
         end
         step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      end
      total++;
      if (emp[0] !== 1'b1 || ovf[0] !== 1'b1) begin
         bad++;
         $display("FAIL drained: got empty=%b ovf=%b, want 1 1", emp[0], ovf[0]);
      end
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      total++;
      if (ovf[0] !== 1'b0) begin
         bad++;
         $display("FAIL clr_ovf: got %b, want 0", ovf[0]);
      end
   endtask

   task automatic test_full_write_pop();
      logic [7:0] last;
      for (int i = 0; i < 16; i++) frame(8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0);
      frame(8'h55, 1'b0, 1'b0, 1'b1);
      total++;
      if (fl[0] !== 5'd16 || ovf[0] !== 1'b0 || ful[0] !== 1'b1) begin
         bad++;
         $display("FAIL full_wr_pop: got fill=%0d ovf=%b full=%b, want 16 0 1", fl[0], ovf[0], ful[0]);
      end
      last = 8'h00;
      for (int i = 0; i < 16; i++) begin
         total++;
         if (rdd[0] !== head(0)[7:0]) begin
            bad++;
            $display("FAIL full_drain[%0d]: got %h, want %h", i, rdd[0], head(0)[7:0]);
         end
         last = rdd[0];
         step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      end
      total++;
      if (last !== 8'h55 || emp[0] !== 1'b1) begin
         bad++;
         $display("FAIL last_is_55: got last=%h empty=%b, want 55 1", last, emp[0]);
      end
   endtask

   task automatic test_hold();
      for (int i = 0; i < 5; i++) step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      total++;
      if (fl[0] !== 5'd1 || rdd[0] !== 8'h3C) begin
         bad++;
         $display("FAIL hold_one_entry: got fill=%0d data=%h, want 1 3c", fl[0], rdd[0]);
      end
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      total++;
      if (fl[0] !== 5'd0 || emp[0] !== 1'b1 || rdd[0] !== 8'h00 || ovf[0] !== 1'b0) begin
         bad++;
         $display("FAIL rd_empty: got fill=%0d empty=%b data=%h ovf=%b, want 0 1 00 0", fl[0], emp[0], rdd[0], ovf[0]);
      end
   endtask

   task automatic test_errors();
      frame(8'h11, 1'b1, 1'b0, 1'b0);
      frame(8'h22, 1'b0, 1'b1, 1'b0);
      total++;
      if (fl[0] !== 5'd2 || rdd[0] !== 8'h11 || rpe[0] !== 1'b1 || rse[0] !== 1'b0 || efc[0] !== 8'd2) begin
         bad++;
         $display("FAIL err_keep: got fill=%0d data=%h pe=%b se=%b efc=%0d, want 2 11 1 0 2",
                  fl[0], rdd[0], rpe[0], rse[0], efc[0]);
      end
      total++;
      if (fl[1] !== 5'd0 || emp[1] !== 1'b1 || efc[1] !== 8'd2 || ovf[1] !== 1'b0) begin
         bad++;
         $display("FAIL err_drop: got fill=%0d empty=%b efc=%0d ovf=%b, want 0 1 2 0", fl[1], emp[1], efc[1], ovf[1]);
      end
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      total++;
      if (rdd[0] !== 8'h22 || rpe[0] !== 1'b0 || rse[0] !== 1'b1) begin
         bad++;
         $display("FAIL err_second: got data=%h pe=%b se=%b, want 22 0 1", rdd[0], rpe[0], rse[0]);
      end
      for (int i = 0; i < 300; i++) frame(8'($urandom), 1'b1, 1'($urandom), 1'b0);
      for (int m = 0; m < 2; m++) begin
         total++;
         if (efc[m] !== 8'd255) begin
            bad++;
            $display("FAIL err_saturate[%0d]: got %0d, want 255", m, efc[m]);
         end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         step(1'($urandom), 8'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0));
         for (int m = 0; m < 2; m++) begin
            total++;
            if ({rpe[m], rse[m], rdd[m]} !== head(m) || fl[m] !== 5'(mq[m].size()) ||
                emp[m] !== (mq[m].size() == 0) || ful[m] !== (mq[m].size() == 16) ||
                ovf[m] !== movf[m] || efc[m] !== 8'(mcnt[m])) begin
               bad++;
               $display("FAIL random[%0d] cyc %0d: got entry=%h fill=%0d ovf=%b efc=%0d, want %h %0d %b %0d",
                        m, c, {rpe[m], rse[m], rdd[m]}, fl[m], ovf[m], efc[m], head(m), mq[m].size(), movf[m], mcnt[m]);
            end
         end
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      frame(8'hE1, 1'b1, 1'b0, 1'b0);
      frame(8'h02, 1'b0, 1'b0, 1'b0);
      frame(8'h03, 1'b0, 1'b0, 1'b0);
      total++;
      if (fl[0] !== 5'd3 || efc[0] !== 8'd1) begin
         bad++;
         $display("FAIL pre_reset: got fill=%0d efc=%0d, want 3 1", fl[0], efc[0]);
      end
      #2 reset_n = 1'b0;
      model_reset();
      #1;
      for (int m = 0; m < 2; m++) begin
         total++;
         if (emp[m] !== 1'b1 || ful[m] !== 1'b0 || fl[m] !== 5'd0 || rdd[m] !== 8'd0 ||
             rpe[m] !== 1'b0 || rse[m] !== 1'b0 || ovf[m] !== 1'b0 || efc[m] !== 8'd0) begin
            bad++;
            $display("FAIL async_reset[%0d]: got empty=%b fill=%0d data=%h efc=%0d, want 1 0 00 0",
                     m, emp[m], fl[m], rdd[m], efc[m]);
         end
      end
      @(negedge clk);
      reset_n = 1'b1;
      frame(8'h77, 1'b0, 1'b0, 1'b0);
      total++;
      if (fl[0] !== 5'd1 || rdd[0] !== 8'h77) begin
         bad++;
         $display("FAIL post_reset: got fill=%0d data=%h, want 1 77", fl[0], rdd[0]);
      end
   endtask

   initial begin
      reset_n = 1'b0;
      data_valid = 0; P_DATA = 0; Parity_Error = 0; Stop_Error = 0; rd_en = 0; clr_ovf = 0;
      model_reset();
      test_reset();
      test_single();
      test_fill_overflow();
      test_full_write_pop();
      test_hold();
      test_errors();
      test_random();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
